// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared state encodings, interval indices and helpers for the alarm controller
package alarm_pkg;

  typedef enum logic [2:0] {
    ARMED       = 3'd0,
    TRIGGERED   = 3'd1,
    SOUND_ALARM = 3'd2,
    DISARMED    = 3'd3,
    WAIT_OPEN   = 3'd4,
    WAIT_CLOSE  = 3'd5,
    ARM_DELAY   = 3'd6
  } state_e;

  localparam logic [1:0] IDX_ARM       = 2'd0;
  localparam logic [1:0] IDX_DRIVER    = 2'd1;
  localparam logic [1:0] IDX_PASSENGER = 2'd2;
  localparam logic [1:0] IDX_ALARM     = 2'd3;

  // A zero interval would never let the countdown run, so it is stored as one second.
  function automatic logic [3:0] clamp_interval(input logic [3:0] v);
    return (v == 4'd0) ? 4'd1 : v;
  endfunction

endpackage

// File: rtl/alarm_controller_if.sv
// rtl/alarm_controller_if.sv - interval register write/read bus between controller and time_parameters
interface alarm_controller_if;
  logic       wr_en;
  logic [1:0] wr_sel;
  logic [3:0] wr_data;
  logic [1:0] rd_idx;
  logic [3:0] rd_data;

  modport master (output wr_en, output wr_sel, output wr_data, output rd_idx, input rd_data);
  modport slave  (input wr_en, input wr_sel, input wr_data, input rd_idx, output rd_data);
endinterface

// File: rtl/alarm_controller_time_parameters.sv
// rtl/alarm_controller_time_parameters.sv - four programmable 4-bit interval registers
module time_parameters
  import alarm_pkg::*;
#(
  parameter logic [3:0] T_ARM_DEFAULT       = 4'd6,
  parameter logic [3:0] T_DRIVER_DEFAULT    = 4'd8,
  parameter logic [3:0] T_PASSENGER_DEFAULT = 4'd15,
  parameter logic [3:0] T_ALARM_DEFAULT     = 4'd10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  alarm_controller_if.slave        tp
);

  logic [3:0] interval_q [4];

  // Load defaults on reset; a write strobe updates the addressed interval on the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      interval_q[IDX_ARM]       <= T_ARM_DEFAULT;
      interval_q[IDX_DRIVER]    <= T_DRIVER_DEFAULT;
      interval_q[IDX_PASSENGER] <= T_PASSENGER_DEFAULT;
      interval_q[IDX_ALARM]     <= T_ALARM_DEFAULT;
    end else if (tp.wr_en) begin
      interval_q[tp.wr_sel] <= clamp_interval(tp.wr_data);
    end
  end

  assign tp.rd_data = interval_q[tp.rd_idx];

endmodule

// File: rtl/alarm_controller.sv
// rtl/alarm_controller.sv - vehicle alarm FSM; ALARM_BLINK_EN enables the armed-state LED blink
module alarm_controller
  import alarm_pkg::*;
#(
  parameter logic [3:0] T_ARM_DEFAULT       = 4'd6,
  parameter logic [3:0] T_DRIVER_DEFAULT    = 4'd8,
  parameter logic [3:0] T_PASSENGER_DEFAULT = 4'd15,
  parameter logic [3:0] T_ALARM_DEFAULT     = 4'd10
) (
  input  logic       clock_25mhz,
  input  logic       reset_n,
  input  logic       ignition,
  input  logic       driver_door,
  input  logic       passenger_door,
  input  logic       reprogram,
  input  logic [1:0] time_param_sel,
  input  logic [3:0] time_value,
  input  logic       one_hz_enable,
  input  logic       expired,
  output logic       start_timer,
  output logic [3:0] value,
  output logic       siren,
  output logic       status_led,
  output logic [2:0] state
);

  alarm_controller_if tp_if ();

  state_e     state_q, state_d;
  logic       siren_q, siren_d;
  logic       led_q, led_d;
  logic       start_q, start_d;
  logic [3:0] value_q, value_d;
  logic       live_q, live_d;       // a countdown we started is still meaningful
  logic       door_prev_q;          // any door open on the previous cycle
  logic       any_open;
  logic       exp_live;
  logic [1:0] rd_idx;

  time_parameters #(
    .T_ARM_DEFAULT      (T_ARM_DEFAULT),
    .T_DRIVER_DEFAULT   (T_DRIVER_DEFAULT),
    .T_PASSENGER_DEFAULT(T_PASSENGER_DEFAULT),
    .T_ALARM_DEFAULT    (T_ALARM_DEFAULT)
  ) u_time_parameters (
    .clk  (clock_25mhz),
    .rst_n(reset_n),
    .tp   (tp_if.slave)
  );

  assign tp_if.wr_en   = reprogram;
  assign tp_if.wr_sel  = time_param_sel;
  assign tp_if.wr_data = time_value;
  assign tp_if.rd_idx  = rd_idx;

  assign any_open = driver_door | passenger_door;
  assign exp_live = expired & live_q;

`ifndef ALARM_BLINK_EN
  logic unused_one_hz;
  assign unused_one_hz = one_hz_enable;
`endif

  // Pick which interval a countdown started this cycle would load.
  always_comb begin
    rd_idx = IDX_ARM;
    if (state_q == ARMED)            rd_idx = driver_door ? IDX_DRIVER : IDX_PASSENGER;
    else if (state_q == SOUND_ALARM) rd_idx = IDX_ALARM;
  end

  // Next-state, countdown bookkeeping and registered-output values.
  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    value_d = value_q;
    live_d  = live_q;
    case (state_q)
      ARMED: begin
        if (ignition) state_d = DISARMED;
        else if (any_open) begin
          state_d = TRIGGERED;
          start_d = 1'b1;
          value_d = tp_if.rd_data;
          live_d  = 1'b1;
        end
      end
      TRIGGERED: begin
        if (ignition) begin
          state_d = DISARMED;
          live_d  = 1'b0;
        end else if (exp_live) begin
          state_d = SOUND_ALARM;
          live_d  = 1'b0;
        end
      end
      SOUND_ALARM: begin
        if (ignition) begin
          state_d = DISARMED;
          live_d  = 1'b0;
        end else if (exp_live && !any_open) begin
          state_d = ARMED;
          live_d  = 1'b0;
        end else if (any_open) begin
          live_d = 1'b0;
        end else if (door_prev_q) begin
          start_d = 1'b1;
          value_d = tp_if.rd_data;
          live_d  = 1'b1;
        end
      end
      DISARMED: begin
        if (!ignition) state_d = WAIT_OPEN;
      end
      WAIT_OPEN: begin
        if (ignition) state_d = DISARMED;
        else if (driver_door) state_d = WAIT_CLOSE;
      end
      WAIT_CLOSE: begin
        if (ignition) state_d = DISARMED;
        else if (!any_open) begin
          state_d = ARM_DELAY;
          start_d = 1'b1;
          value_d = tp_if.rd_data;
          live_d  = 1'b1;
        end
      end
      ARM_DELAY: begin
        if (ignition) begin
          state_d = DISARMED;
          live_d  = 1'b0;
        end else if (exp_live) begin
          state_d = ARMED;
          live_d  = 1'b0;
        end else if (any_open) begin
          state_d = WAIT_CLOSE;
          live_d  = 1'b0;
        end
      end
      default: begin
        state_d = ARMED;
        live_d  = 1'b0;
      end
    endcase

    if (reprogram) begin
      state_d = ARMED;
      start_d = 1'b0;
      value_d = value_q;
      live_d  = 1'b0;
    end

    siren_d = (state_d == SOUND_ALARM);
    led_d   = (state_d == TRIGGERED) || (state_d == SOUND_ALARM);
`ifdef ALARM_BLINK_EN
    if (state_d == ARMED)
      led_d = (state_q == ARMED && !reprogram) ? (led_q ^ one_hz_enable) : 1'b0;
`endif
  end

  // State and output registers with asynchronous reset to a quiet ARMED state.
  always_ff @(posedge clock_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ARMED;
      siren_q     <= 1'b0;
      led_q       <= 1'b0;
      start_q     <= 1'b0;
      value_q     <= 4'd0;
      live_q      <= 1'b0;
      door_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      siren_q     <= siren_d;
      led_q       <= led_d;
      start_q     <= start_d;
      value_q     <= value_d;
      live_q      <= live_d;
      door_prev_q <= any_open;
    end
  end

  assign start_timer = start_q;
  assign value       = value_q;
  assign siren       = siren_q;
  assign status_led  = led_q;
  assign state       = state_q;

endmodule

// File: tb/tb_alarm_controller.sv
// tb/tb_alarm_controller.sv - directed self-checking bench for alarm_controller
module tb_alarm_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ignition, driver_door, passenger_door;
  logic       one_hz_enable, expired;
  logic       start_timer, siren, status_led;
  logic [3:0] value;
  logic [2:0] state;
  int         total = 0;
  int         bad = 0;

  alarm_controller_if cfg ();

  alarm_controller dut (
    .clock_25mhz   (clk),
    .reset_n       (rst_n),
    .ignition      (ignition),
    .driver_door   (driver_door),
    .passenger_door(passenger_door),
    .reprogram     (cfg.wr_en),
    .time_param_sel(cfg.wr_sel),
    .time_value    (cfg.wr_data),
    .one_hz_enable (one_hz_enable),
    .expired       (expired),
    .start_timer   (start_timer),
    .value         (value),
    .siren         (siren),
    .status_led    (status_led),
    .state         (state)
  );

  always #20 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; ignition = 0; driver_door = 0; passenger_door = 0;
    one_hz_enable = 0; expired = 0;
    cfg.wr_en = 0; cfg.wr_sel = 0; cfg.wr_data = 0;
    #50;
    chk("rst_state", {5'd0, state}, 8'd0);
    chk("rst_siren", {7'd0, siren}, 8'd0);
    chk("rst_led", {7'd0, status_led}, 8'd0);
    chk("rst_start", {7'd0, start_timer}, 8'd0);
    chk("rst_value", {4'd0, value}, 8'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    chk("armed_idle", {5'd0, state}, 8'd0);

    one_hz_enable = 1; tick(); one_hz_enable = 0;
`ifdef ALARM_BLINK_EN
    chk("armed_led_hz", {7'd0, status_led}, 8'd1);
`else
    chk("armed_led_hz", {7'd0, status_led}, 8'd0);
`endif

    // driver door trips the alarm with the driver interval
    driver_door = 1; tick();
    chk("trig_state", {5'd0, state}, 8'd1);
    chk("trig_start", {7'd0, start_timer}, 8'd1);
    chk("trig_value", {4'd0, value}, 8'd8);
    chk("trig_led", {7'd0, status_led}, 8'd1);
    tick();
    chk("trig_one_pulse", {7'd0, start_timer}, 8'd0);

    // ignition disarms, then driver open/close arms with interval 0
    ignition = 1; tick();
    chk("disarm_state", {5'd0, state}, 8'd3);
    chk("disarm_led", {7'd0, status_led}, 8'd0);
    ignition = 0; driver_door = 0; tick();
    chk("wait_open", {5'd0, state}, 8'd4);
    driver_door = 1; tick();
    chk("wait_close", {5'd0, state}, 8'd5);
    driver_door = 0; tick();
    chk("arm_delay", {5'd0, state}, 8'd6);
    chk("arm_start", {7'd0, start_timer}, 8'd1);
    chk("arm_value", {4'd0, value}, 8'd6);
    tick();
    expired = 1; tick(); expired = 0;
    chk("armed_again", {5'd0, state}, 8'd0);

    // reprogram passenger interval to 3
    cfg.wr_en = 1; cfg.wr_sel = 2'd2; cfg.wr_data = 4'd3; tick(); cfg.wr_en = 0;
    chk("reprog_state", {5'd0, state}, 8'd0);
    chk("reprog_start", {7'd0, start_timer}, 8'd0);
    passenger_door = 1; tick();
    chk("pass_state", {5'd0, state}, 8'd1);
    chk("pass_value", {4'd0, value}, 8'd3);
    tick();
    expired = 1; tick(); expired = 0;
    chk("sound_state", {5'd0, state}, 8'd2);
    chk("sound_siren", {7'd0, siren}, 8'd1);

    // close starts the hold countdown; reopen voids it
    passenger_door = 0; tick();
    chk("hold_start", {7'd0, start_timer}, 8'd1);
    chk("hold_value", {4'd0, value}, 8'd10);
    tick();
    passenger_door = 1; tick();
    expired = 1; tick(); expired = 0;
    chk("void_state", {5'd0, state}, 8'd2);
    chk("void_siren", {7'd0, siren}, 8'd1);
    passenger_door = 0; tick();
    chk("rehold_start", {7'd0, start_timer}, 8'd1);
    tick();
    expired = 1; tick(); expired = 0;
    chk("rearm_state", {5'd0, state}, 8'd0);
    chk("rearm_siren", {7'd0, siren}, 8'd0);
    chk("rearm_led", {7'd0, status_led}, 8'd0);

    // ARM_DELAY door reopen, then ignition beats expired
    ignition = 1; tick(); ignition = 0; tick();
    driver_door = 1; tick(); driver_door = 0; tick();
    chk("ad2_state", {5'd0, state}, 8'd6);
    passenger_door = 1; tick();
    chk("ad_reopen", {5'd0, state}, 8'd5);
    passenger_door = 0; tick();
    chk("ad3_state", {5'd0, state}, 8'd6);
    ignition = 1; expired = 1; tick(); expired = 0;
    chk("ign_over_exp", {5'd0, state}, 8'd3);
    ignition = 0;

    // reprogram driver interval with 0 (stored as 1), alarm, then reset mid-alarm
    cfg.wr_en = 1; cfg.wr_sel = 2'd1; cfg.wr_data = 4'd0; tick(); cfg.wr_en = 0;
    chk("reprog2_state", {5'd0, state}, 8'd0);
    driver_door = 1; tick();
    chk("clamp_value", {4'd0, value}, 8'd1);
    tick();
    expired = 1; tick(); expired = 0;
    chk("sound2_siren", {7'd0, siren}, 8'd1);
    rst_n = 1'b0; #1;
    chk("async_siren", {7'd0, siren}, 8'd0);
    chk("async_state", {5'd0, state}, 8'd0);
    driver_door = 0;
    @(negedge clk); rst_n = 1'b1;
    tick();
    expired = 1; tick(); expired = 0;
    chk("post_rst_exp", {5'd0, state}, 8'd0);
    chk("post_rst_start", {7'd0, start_timer}, 8'd0);

    // reprogram overrides a door event in the same cycle
    driver_door = 1; cfg.wr_en = 1; cfg.wr_sel = 2'd3; cfg.wr_data = 4'd5; tick(); cfg.wr_en = 0;
    chk("override_state", {5'd0, state}, 8'd0);
    chk("override_start", {7'd0, start_timer}, 8'd0);
    tick();
    chk("after_override", {5'd0, state}, 8'd1);
    driver_door = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alarm_controller.md
ALARM_CONTROLLER -- requirements
Module: alarm_controller

Interface
REQ-001 SHALL have parameter T_ARM_DEFAULT, 4'd6, arm-delay seconds loaded at reset.
REQ-002 SHALL have parameter T_DRIVER_DEFAULT, 4'd8, driver-door countdown seconds.
REQ-003 SHALL have parameter T_PASSENGER_DEFAULT, 4'd15, passenger-door countdown seconds.
REQ-004 SHALL have parameter T_ALARM_DEFAULT, 4'd10, siren hold seconds after doors close.
REQ-005 SHALL have port clock_25mhz  input  1  system clock; all state changes on its rising edge.
REQ-006 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have ports ignition, driver_door, passenger_door  input  1 each  synchronized, debounced levels, 1 = on/open.
REQ-008 SHALL have port reprogram  input  1  one-cycle write strobe.
REQ-009 SHALL have ports time_param_sel  input  2  and time_value  input  4  write address/data.
REQ-010 SHALL have port one_hz_enable  input  1  one-cycle pulse per second.
REQ-011 SHALL have port expired  input  1  one-cycle pulse from the shared countdown timer.
REQ-012 SHALL have ports start_timer  output  1  and value  output  4  timer load pulse and count.
REQ-013 SHALL have ports siren, status_led  output  1 each, and state  output  3  for the 7-segment display.

Function
REQ-014 SHALL hold four 4-bit interval registers indexed 0 arm, 1 driver, 2 passenger, 3 alarm.
REQ-015 SHALL, on reprogram, write time_value to register time_param_sel next edge; time_value 0 SHALL store as 1.
REQ-016 SHALL, on reprogram, also go to ARMED with siren 0 and start_timer 0, overriding every other event that cycle.
REQ-017 SHALL register all outputs; start_timer SHALL be one cycle wide, with value valid in the same cycle.
REQ-018 SHALL apply event priority reprogram > ignition > expired > door events.
REQ-019 ARMED: ignition -> DISARMED; else driver_door -> TRIGGERED, start with interval 1; else passenger_door -> TRIGGERED, start with interval 2.
REQ-020 TRIGGERED: status_led 1; ignition -> DISARMED; expired -> SOUND_ALARM, siren 1 next cycle.
REQ-021 SOUND_ALARM: siren 1 and status_led 1 while any door is open.
REQ-022 SOUND_ALARM: the cycle all doors become closed after any was open SHALL start interval 3.
REQ-023 SOUND_ALARM: a door reopening SHALL void that countdown, and a later expired SHALL be ignored.
REQ-024 SOUND_ALARM: expired with all doors closed and a live countdown -> ARMED, siren 0; ignition -> DISARMED, siren 0.
REQ-025 DISARMED: siren 0, status_led 0; ignition low -> WAIT_OPEN.
REQ-026 WAIT_OPEN: driver_door -> WAIT_CLOSE.
REQ-027 WAIT_CLOSE: both doors closed -> ARM_DELAY and start interval 0.
REQ-028 ARM_DELAY: any door open -> WAIT_CLOSE; expired -> ARMED.
REQ-029 In WAIT_OPEN, WAIT_CLOSE and ARM_DELAY, ignition high SHALL go to DISARMED.
REQ-030 SHALL ignore expired in every state and cycle where no countdown it started is live.
REQ-031 SHALL ignore one_hz_enable except as REQ-037 allows.

Reset
REQ-032 SHALL, on reset_n low, asynchronously set state ARMED, siren 0, status_led 0, start_timer 0 and value 0.
REQ-033 SHALL, on reset_n low, load the interval registers with their *_DEFAULT values.
REQ-034 SHALL release from reset synchronously on the first clock_25mhz edge after reset_n rises.
REQ-035 Reset mid-countdown SHALL drop any pending countdown; a following expired SHALL be ignored.

Configuration
REQ-036 SHALL recognise macro ALARM_BLINK_EN.
REQ-037 With ALARM_BLINK_EN, status_led in ARMED SHALL toggle on each one_hz_enable, starting at 0 on entry.
REQ-038 Without ALARM_BLINK_EN, status_led in ARMED SHALL be constant 0 and one_hz_enable SHALL be unused.

Structure
REQ-039 SHALL take state encodings from shared package alarm_pkg: ARMED 0, TRIGGERED 1, SOUND_ALARM 2, DISARMED 3, WAIT_OPEN 4, WAIT_CLOSE 5, ARM_DELAY 6.
REQ-040 SHALL take interval index constants IDX_ARM, IDX_DRIVER, IDX_PASSENGER, IDX_ALARM from alarm_pkg.
REQ-041 SHALL place the interval registers and write logic in sub-module time_parameters, with a 2-bit read index giving a 4-bit interval.

Verification
REQ-042 Reset, driver_door 1 -> TRIGGERED, one start_timer pulse with value 8.
REQ-043 Reprogram sel 2 data 3, passenger_door 1 -> value 3; then expired -> siren 1.
REQ-044 In SOUND_ALARM, close doors -> start value 10; reopen, then expired -> siren stays 1; close doors, then expired -> ARMED, siren 0.
REQ-045 Ignition 1 in TRIGGERED -> DISARMED; ignition 0 -> driver open/close -> start value 6; expired -> ARMED.
REQ-046 In ARM_DELAY, passenger_door 1 -> WAIT_CLOSE; ignition 1 together with expired -> DISARMED.
REQ-047 reset_n low mid-SOUND_ALARM -> siren 0 immediately; then expired -> state stays ARMED.
